// File: rtl/mem_arb_pkg.sv
// Shared definitions for the block-RAM port arbiter: default widths, pending-read
// state encoding and requester ids (also used for the round-robin last-winner bit).
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_IF   = 2'd1,
    PEND_D    = 2'd2
  } pend_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// One-hot grant picker for the fetch and data ports. With MEMARB_RR_EN defined a
// conflict goes to the port that lost the previous conflict; otherwise data wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_if_req,
  input  logic i_d_req,
`ifdef MEMARB_RR_EN
  input  logic i_last_win,
`endif
  output logic o_if_gnt,
  output logic o_d_gnt
);

  logic w_conflict;
  assign w_conflict = i_if_req & i_d_req;

  always_comb begin
    o_if_gnt = 1'b0;
    o_d_gnt  = 1'b0;
    if (w_conflict) begin
`ifdef MEMARB_RR_EN
      if (i_last_win == REQ_D) o_if_gnt = 1'b1;
      else                     o_d_gnt  = 1'b1;
`else
      o_d_gnt = 1'b1;
`endif
    end else begin
      o_if_gnt = i_if_req;
      o_d_gnt  = i_d_req;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port block RAM between instruction fetch and load/store, returns
// read data one cycle after the RAM read. Optional round-robin via MEMARB_RR_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic              w_if_pick;
  logic              w_d_pick;
  logic              w_conflict;
  pend_e             r_pend;
  pend_e             w_pend_nxt;
  logic              r_if_rvalid;
  logic              r_d_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic [CNT_W-1:0]  r_cnt;

  assign w_conflict = if_req & d_req;

`ifdef MEMARB_RR_EN
  logic r_last_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_last_win <= REQ_IF;
    else if (w_conflict) r_last_win <= w_d_pick ? REQ_D : REQ_IF;
  end
`endif

  mem_arb_pick u_pick (
    .i_if_req   (if_req),
    .i_d_req    (d_req),
`ifdef MEMARB_RR_EN
    .i_last_win (r_last_win),
`endif
    .o_if_gnt   (w_if_pick),
    .o_d_gnt    (w_d_pick)
  );

  // Grants are suppressed during reset so no RAM write or read can slip through.
  assign if_gnt      = w_if_pick & ~rst;
  assign d_gnt       = w_d_pick & ~rst;
  assign ram_address = d_gnt ? d_addr : if_addr;
  assign ram_wren    = d_gnt & d_we;
  assign ram_data    = d_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pend <= PEND_NONE;
    else     r_pend <= w_pend_nxt;
  end

  always_comb begin
    w_pend_nxt = PEND_NONE;
    if (if_gnt)              w_pend_nxt = PEND_IF;
    else if (d_gnt && !d_we) w_pend_nxt = PEND_D;
  end

  // ram_q is valid during the pend cycle; capture it so data and rvalid appear together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_if_rvalid <= (r_pend == PEND_IF);
      r_d_rvalid  <= (r_pend == PEND_D);
      if (r_pend == PEND_IF) r_if_rdata <= ram_q;
      if (r_pend == PEND_D)  r_d_rdata  <= ram_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           r_cnt <= '0;
    else if (w_conflict && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end

  assign if_rvalid    = r_if_rvalid;
  assign d_rvalid     = r_d_rvalid;
  assign if_rdata     = r_if_rdata;
  assign d_rdata      = r_d_rdata;
  assign conflict_cnt = r_cnt;

endmodule
